// File: rtl/gpu_line_pkg.sv
// Shared types and constants for the Bresenham line rasteriser.
// ERR_W is derived from the coordinate widths so that the signed error term never overflows.
package gpu_line_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      DRAW,
      DONE
   } line_state_t;

   localparam int unsigned ScreenW = 640;
   localparam int unsigned ScreenH = 480;
   localparam int unsigned DefXMax = ScreenW - 1;
   localparam int unsigned DefYMax = ScreenH - 1;
   localparam int unsigned DefXW   = 10;
   localparam int unsigned DefYW   = 9;

   // Two guard bits: one for the sign, one so that err + dx + dy still fits.
   function automatic int unsigned err_width(input int unsigned xw, input int unsigned yw);
      return ((xw > yw) ? xw : yw) + 2;
   endfunction

   localparam int unsigned ERR_W = err_width(DefXW, DefYW);

endpackage

// File: rtl/gpu_line_raster_if.sv
// Request and pixel-stream bundle between the draw path and the line rasteriser.
// The rasteriser uses the slave side; the requester/pixel consumer uses the master side.
interface gpu_line_raster_if #(
   parameter int unsigned XW = 10,
   parameter int unsigned YW = 9
);

   logic          start;
   logic [XW-1:0] x1;
   logic [XW-1:0] x2;
   logic [YW-1:0] y1;
   logic [YW-1:0] y2;
   logic          busy;
   logic          done;
   logic          pix_valid;
   logic          pix_ready;
   logic [XW-1:0] pos_x;
   logic [YW-1:0] pos_y;
   logic          pix_last;

   modport master (
      output start, x1, x2, y1, y2, pix_ready,
      input  busy, done, pix_valid, pos_x, pos_y, pix_last
   );

   modport slave (
      input  start, x1, x2, y1, y2, pix_ready,
      output busy, done, pix_valid, pos_x, pos_y, pix_last
   );

endinterface

// File: rtl/gpu_line_step.sv
// Combinational Bresenham step: from the current point and error term, produce the next
// point and error. Both axis updates may apply in the same step.
module gpu_line_step
   import gpu_line_pkg::*;
#(
   parameter int unsigned XW = 10,
   parameter int unsigned YW = 9,
   parameter int unsigned EW = err_width(XW, YW)
) (
   input  logic [XW-1:0]        cur_x_i,
   input  logic [YW-1:0]        cur_y_i,
   input  logic signed [EW-1:0] err_i,
   input  logic signed [EW-1:0] dx_i,
   input  logic signed [EW-1:0] dy_i,
   input  logic                 sx_neg_i,
   input  logic                 sy_neg_i,
   output logic [XW-1:0]        nxt_x_o,
   output logic [YW-1:0]        nxt_y_o,
   output logic signed [EW-1:0] nxt_err_o
);

   logic signed [EW:0] e2;
   logic signed [EW:0] dx_ext;
   logic signed [EW:0] dy_ext;
   logic               step_x;
   logic               step_y;

   always_comb begin
      e2     = {err_i, 1'b0};
      dx_ext = {dx_i[EW-1], dx_i};
      dy_ext = {dy_i[EW-1], dy_i};
      step_x = (e2 >= dy_ext);
      step_y = (e2 <= dx_ext);

      nxt_err_o = err_i;
      nxt_x_o   = cur_x_i;
      nxt_y_o   = cur_y_i;

      if (step_x) begin
         nxt_err_o = nxt_err_o + dy_i;
         nxt_x_o   = sx_neg_i ? (cur_x_i - XW'(1)) : (cur_x_i + XW'(1));
      end
      if (step_y) begin
         nxt_err_o = nxt_err_o + dx_i;
         nxt_y_o   = sy_neg_i ? (cur_y_i - YW'(1)) : (cur_y_i + YW'(1));
      end
   end

endmodule

// File: rtl/gpu_line_raster.sv
// Bresenham line rasteriser: latches two endpoints and streams every pixel of the line,
// one per cycle, on a valid/ready interface, optionally dropping off-screen pixels.
module gpu_line_raster
   import gpu_line_pkg::*;
#(
   parameter int unsigned XW      = 10,
   parameter int unsigned YW      = 9,
   parameter bit          CLIP_EN = 1'b1,
   parameter int unsigned X_MAX   = DefXMax,
   parameter int unsigned Y_MAX   = DefYMax
) (
   input  logic               clk_i,
   input  logic               reset_i,
   gpu_line_raster_if.slave   bus_io
);

   localparam int unsigned EW = err_width(XW, YW);

   line_state_t          state_q, state_d;
   logic [XW-1:0]        cur_x_q, cur_x_d;
   logic [YW-1:0]        cur_y_q, cur_y_d;
   logic [XW-1:0]        x2_q, x2_d;
   logic [YW-1:0]        y2_q, y2_d;
   logic signed [EW-1:0] err_q, err_d;
   logic signed [EW-1:0] dx_q, dx_d;
   logic signed [EW-1:0] dy_q, dy_d;
   logic                 sx_neg_q, sx_neg_d;
   logic                 sy_neg_q, sy_neg_d;

   logic [XW-1:0]        nxt_x;
   logic [YW-1:0]        nxt_y;
   logic signed [EW-1:0] nxt_err;

   logic signed [EW-1:0] x1_s, x2_s, y1_s, y2_s;
   logic signed [EW-1:0] dx_abs, dy_abs;
   logic                 sx_neg, sy_neg;
   logic                 visible;
   logic                 at_end;
   logic                 advance;

   gpu_line_step #(
      .XW (XW),
      .YW (YW),
      .EW (EW)
   ) u_step (
      .cur_x_i   (cur_x_q),
      .cur_y_i   (cur_y_q),
      .err_i     (err_q),
      .dx_i      (dx_q),
      .dy_i      (dy_q),
      .sx_neg_i  (sx_neg_q),
      .sy_neg_i  (sy_neg_q),
      .nxt_x_o   (nxt_x),
      .nxt_y_o   (nxt_y),
      .nxt_err_o (nxt_err)
   );

   // Setup arithmetic: the start point already sits in cur_x_q/cur_y_q after IDLE.
   always_comb begin
      x1_s   = EW'(cur_x_q);
      x2_s   = EW'(x2_q);
      y1_s   = EW'(cur_y_q);
      y2_s   = EW'(y2_q);
      sx_neg = (x2_q < cur_x_q);
      sy_neg = (y2_q < cur_y_q);
      dx_abs = sx_neg ? (x1_s - x2_s) : (x2_s - x1_s);
      dy_abs = sy_neg ? (y1_s - y2_s) : (y2_s - y1_s);
   end

   always_comb begin
      visible = !CLIP_EN || ((32'(cur_x_q) <= X_MAX) && (32'(cur_y_q) <= Y_MAX));
      at_end  = (cur_x_q == x2_q) && (cur_y_q == y2_q);
      // A clipped point steps on unconditionally; a visible one waits for the consumer.
      advance = visible ? bus_io.pix_ready : 1'b1;
   end

   always_comb begin
      state_d  = state_q;
      cur_x_d  = cur_x_q;
      cur_y_d  = cur_y_q;
      x2_d     = x2_q;
      y2_d     = y2_q;
      err_d    = err_q;
      dx_d     = dx_q;
      dy_d     = dy_q;
      sx_neg_d = sx_neg_q;
      sy_neg_d = sy_neg_q;

      unique case (state_q)
         IDLE: begin
            if (bus_io.start) begin
               cur_x_d = bus_io.x1;
               cur_y_d = bus_io.y1;
               x2_d    = bus_io.x2;
               y2_d    = bus_io.y2;
               state_d = SETUP;
            end
         end
         SETUP: begin
            dx_d     = dx_abs;
            dy_d     = -dy_abs;
            err_d    = dx_abs - dy_abs;
            sx_neg_d = sx_neg;
            sy_neg_d = sy_neg;
            state_d  = DRAW;
         end
         DRAW: begin
            if (advance) begin
               if (at_end) begin
                  state_d = DONE;
               end else begin
                  cur_x_d = nxt_x;
                  cur_y_d = nxt_y;
                  err_d   = nxt_err;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= IDLE;
         cur_x_q  <= '0;
         cur_y_q  <= '0;
         x2_q     <= '0;
         y2_q     <= '0;
         err_q    <= '0;
         dx_q     <= '0;
         dy_q     <= '0;
         sx_neg_q <= 1'b0;
         sy_neg_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cur_x_q  <= cur_x_d;
         cur_y_q  <= cur_y_d;
         x2_q     <= x2_d;
         y2_q     <= y2_d;
         err_q    <= err_d;
         dx_q     <= dx_d;
         dy_q     <= dy_d;
         sx_neg_q <= sx_neg_d;
         sy_neg_q <= sy_neg_d;
      end
   end

   // Outputs come straight from registers, so they hold while the consumer stalls.
   always_comb begin
      bus_io.busy      = (state_q == SETUP) || (state_q == DRAW);
      bus_io.done      = (state_q == DONE);
      bus_io.pix_valid = (state_q == DRAW) && visible;
      bus_io.pix_last  = (state_q == DRAW) && visible && at_end;
      bus_io.pos_x     = cur_x_q;
      bus_io.pos_y     = cur_y_q;
   end

endmodule

// File: tb/tb_gpu_line_raster.sv
// Scoreboard bench for gpu_line_raster: stimulus queues expected pixels, a monitor pops and
// compares each accepted pixel and checks that stalled outputs hold.
module tb_gpu_line_raster;

   typedef struct {
      int x;
      int y;
      int last;
   } pix_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   acc_cnt = 0;
   bit   rand_rdy = 1'b0;
   pix_t exp_q[$];

   gpu_line_raster_if #(.XW(10), .YW(9)) bus_if ();

   gpu_line_raster #(
      .XW      (10),
      .YW      (9),
      .CLIP_EN (1'b1),
      .X_MAX   (639),
      .Y_MAX   (479)
   ) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus_io  (bus_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic push_pix(input int x, input int y, input int last);
      pix_t p;
      p.x = x; p.y = y; p.last = last;
      exp_q.push_back(p);
   endtask

   // Golden software Bresenham with screen clipping at 639x479.
   task automatic push_line(input int x1, input int y1, input int x2, input int y2);
      int dx, dy, sx, sy, err, e2, x, y;
      dx  = (x2 >= x1) ? x2 - x1 : x1 - x2;
      dy  = (y2 >= y1) ? y1 - y2 : y2 - y1;
      sx  = (x2 >= x1) ? 1 : -1;
      sy  = (y2 >= y1) ? 1 : -1;
      err = dx + dy;
      x   = x1;
      y   = y1;
      while (1) begin
         if (x <= 639 && y <= 479) push_pix(x, y, (x == x2 && y == y2) ? 1 : 0);
         if (x == x2 && y == y2) break;
         e2 = 2 * err;
         if (e2 >= dy) begin err += dy; x += sx; end
         if (e2 <= dx) begin err += dx; y += sy; end
      end
   endtask

   // Expects to be entered just after a rising edge with the DUT idle.
   task automatic run_line(input int x1, input int y1, input int x2, input int y2,
                           input int exp_done, input int poke, input int first_last);
      int  c0, off;
      bit  got_done;
      bus_if.start = 1'b1;
      bus_if.x1 = 10'(x1); bus_if.y1 = 9'(y1);
      bus_if.x2 = 10'(x2); bus_if.y2 = 9'(y2);
      c0 = cyc;
      @(posedge clk); #1;
      bus_if.start = 1'b0;
      check("busy_after_start", int'(bus_if.busy), 1);
      got_done = 1'b0;
      for (int i = 0; i < 4000 && !got_done; i++) begin
         @(negedge clk);
         off = cyc - c0;
         if (first_last >= 0 && off == 2) begin
            check("first_valid", int'(bus_if.pix_valid), 1);
            check("first_last", int'(bus_if.pix_last), first_last);
         end
         if (bus_if.done) begin
            got_done = 1'b1;
            if (exp_done >= 0) check("done_cycle", off, exp_done);
            check("busy_at_done", int'(bus_if.busy), 0);
         end else begin
            @(posedge clk); #1;
            bus_if.start = (off + 1 == poke);
            if (off + 1 == poke) begin
               bus_if.x1 = 10'd100; bus_if.y1 = 9'd100;
               bus_if.x2 = 10'd3;   bus_if.y2 = 9'd3;
            end
         end
      end
      if (!got_done) check("done_timeout", 0, 1);
      check("pixels_left", exp_q.size(), 0);
      @(posedge clk); #1;
      bus_if.start = 1'b0;
   endtask

   // Ready driver: always high, or a coin flip per cycle.
   initial begin
      bus_if.pix_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         bus_if.pix_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: compares accepted pixels against the scoreboard and checks stall stability.
   initial begin
      bit          prev_stall;
      logic [20:0] prev_w, cur_w;
      pix_t        e;
      prev_stall = 1'b0;
      prev_w     = '0;
      forever begin
         @(negedge clk);
         cur_w = {bus_if.pix_valid, bus_if.pos_x, bus_if.pos_y, bus_if.pix_last};
         if (reset) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) check("stall_hold", int'(cur_w), int'(prev_w));
            if (bus_if.pix_valid && bus_if.pix_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_pixel", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("pix_x", int'(bus_if.pos_x), e.x);
                  check("pix_y", int'(bus_if.pos_y), e.y);
                  check("pix_last", int'(bus_if.pix_last), e.last);
               end
               acc_cnt++;
            end
            prev_stall = bus_if.pix_valid && !bus_if.pix_ready;
            prev_w     = cur_w;
         end
      end
   end

   task automatic check_reset_outputs();
      check("rst_busy", int'(bus_if.busy), 0);
      check("rst_done", int'(bus_if.done), 0);
      check("rst_valid", int'(bus_if.pix_valid), 0);
      check("rst_last", int'(bus_if.pix_last), 0);
      check("rst_pos_x", int'(bus_if.pos_x), 0);
      check("rst_pos_y", int'(bus_if.pos_y), 0);
   endtask

   initial begin
      bus_if.start = 1'b0;
      bus_if.x1 = '0; bus_if.y1 = '0; bus_if.x2 = '0; bus_if.y2 = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_reset_outputs();
      @(posedge clk); #1;

      // Shallow line, hand-computed.
      push_pix(0, 0, 0); push_pix(1, 0, 0); push_pix(2, 1, 0);
      push_pix(3, 1, 0); push_pix(4, 2, 0); push_pix(5, 2, 1);
      run_line(0, 0, 5, 2, 8, -1, 0);

      // Steep line with negative x step, hand-computed.
      push_pix(7, 3, 0); push_pix(6, 4, 0); push_pix(5, 5, 0); push_pix(4, 6, 0);
      push_pix(4, 7, 0); push_pix(3, 8, 0); push_pix(2, 9, 1);
      run_line(7, 3, 2, 9, 9, -1, 0);

      // Degenerate single-point line.
      push_pix(10, 10, 1);
      run_line(10, 10, 10, 10, 3, -1, 1);

      // Horizontal line under random backpressure, with a start pulsed mid-line.
      rand_rdy = 1'b1;
      push_line(0, 0, 20, 0);
      run_line(0, 0, 20, 0, -1, 6, -1);
      rand_rdy = 1'b0;
      @(posedge clk); #1;

      // Line crossing the right screen edge: only x 630..639 come out, no pix_last.
      push_line(630, 470, 650, 470);
      run_line(630, 470, 650, 470, 23, -1, 0);

      // Long diagonal abandoned by reset at the 100th pixel.
      acc_cnt = 0;
      push_line(0, 0, 639, 479);
      bus_if.start = 1'b1;
      bus_if.x1 = 10'd0; bus_if.y1 = 9'd0; bus_if.x2 = 10'd639; bus_if.y2 = 9'd479;
      @(posedge clk); #1;
      bus_if.start = 1'b0;
      for (int i = 0; i < 2000 && acc_cnt < 99; i++) begin
         @(posedge clk); #1;
      end
      check("reached_pixel_99", (acc_cnt >= 99) ? 1 : 0, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check_reset_outputs();
      @(posedge clk); #1;

      // Fresh line after the reset.
      push_line(3, 4, 8, 1);
      run_line(3, 4, 8, 1, 8, -1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
